// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal agent: packet field offsets,
// RX state encoding, counter width and terminal coordinate helpers.
package mesh_term_pkg;

    // Counter width for tx_cnt / rx_cnt (saturating).
    localparam int CNT_W = 16;

    // Field positions are given as offsets from PCKG_SZ so they scale
    // with the packet width: row MSB = PCKG_SZ-9, col MSB = PCKG_SZ-13,
    // ID MSB = PCKG_SZ-17, broadcast ID width = PCKG_SZ-18.
    localparam int ROW_MSB_OFS = 9;
    localparam int COL_MSB_OFS = 13;
    localparam int ID_MSB_OFS  = 17;
    localparam int BDCST_OFS   = 18;
    localparam int FIELD_W     = 4;

    // Per-terminal RX sequencing states.
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_POP  = 2'd1,
        RX_HOLD = 2'd2
    } rx_state_e;

    // Terminals are numbered top edge, bottom edge, left edge, right edge.
    function automatic int term_row(input int i, input int rows, input int cols);
        if (i < cols)                 return 0;
        else if (i < 2*cols)          return rows + 1;
        else if (i < 2*cols + rows)   return i - 2*cols + 1;
        else                          return i - 2*cols - rows + 1;
    endfunction

    function automatic int term_col(input int i, input int rows, input int cols);
        if (i < cols)                 return i + 1;
        else if (i < 2*cols)          return i - cols + 1;
        else if (i < 2*cols + rows)   return 0;
        else                          return cols + 1;
    endfunction

endpackage

// File: rtl/mesh_term_agent_if.sv
// Bundle of all per-terminal host/mesh signals of the terminal agent.
//
// Handshake semantics:
//   TX host side : push is a write strobe; a push is accepted on a rising
//                  edge when full is low, or when full is high and popin
//                  removes the head on that same edge. Otherwise it is
//                  dropped and ovf latches.
//   TX mesh side : pndng_i_in is a valid flag with data_out_i_in as payload;
//                  popin acts as ready and consumes the head on the edge.
//   RX mesh side : pndng is valid with data_out as payload; pop is the
//                  one-cycle consume strobe, data_out is captured that edge.
//   RX host side : rx_ready gates the start of a transfer only; rx_valid is
//                  a one-cycle strobe that the host must take unconditionally.
interface mesh_term_agent_if
    import mesh_term_pkg::*;
#(
    parameter int PCKG_SZ = 40,
    parameter int TERMS   = 16
);
    logic [TERMS-1:0]         push;
    logic [TERMS*PCKG_SZ-1:0] push_data;
    logic [TERMS-1:0]         full;
    logic [TERMS-1:0]         pndng_i_in;
    logic [TERMS*PCKG_SZ-1:0] data_out_i_in;
    logic [TERMS-1:0]         popin;
    logic [TERMS-1:0]         pndng;
    logic [TERMS*PCKG_SZ-1:0] data_out;
    logic [TERMS-1:0]         pop;
    logic [TERMS-1:0]         rx_ready;
    logic [TERMS-1:0]         rx_valid;
    logic [TERMS*PCKG_SZ-1:0] rx_data;
    logic [TERMS-1:0]         ovf;
    logic [TERMS-1:0]         misroute;
    logic [TERMS*CNT_W-1:0]   tx_cnt;
    logic [TERMS*CNT_W-1:0]   rx_cnt;
    logic [TERMS*2-1:0]       rx_state;   // debug view of each RX FSM

    modport master (
        output push, push_data, popin, pndng, data_out, rx_ready,
        input  full, pndng_i_in, data_out_i_in, pop, rx_valid, rx_data,
               ovf, misroute, tx_cnt, rx_cnt, rx_state
    );

    modport slave (
        input  push, push_data, popin, pndng, data_out, rx_ready,
        output full, pndng_i_in, data_out_i_in, pop, rx_valid, rx_data,
               ovf, misroute, tx_cnt, rx_cnt, rx_state
    );
endinterface

// File: rtl/mesh_term_fifo.sv
// Single-channel TX FIFO. Head is presented combinationally and reads as
// zero while empty so the mesh side never sees stale storage.
module mesh_term_fifo #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [PCKG_SZ-1:0] head,
    output logic               popped,
    output logic               dropped
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic               wr_en;

    assign full    = (count == OCC_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign popped  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign wr_en   = push && (!full || popped);
    assign dropped = push && !wr_en;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array, not reset: contents are only visible through head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (popped) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, popped})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mesh_term_agent.sv
// Mesh terminal agent: one TX FIFO and one RX sequencer per terminal, all
// channels fully independent. Tracks overflow, misrouting and traffic counts.
module mesh_term_agent
    import mesh_term_pkg::*;
#(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int TERMS      = 2*ROWS + 2*COLUMS,
    parameter logic [PCKG_SZ-BDCST_OFS-1:0] BDCST = {PCKG_SZ-BDCST_OFS{1'b1}}
) (
    input logic              clk,
    input logic              reset,
    mesh_term_agent_if.slave bus
);
    localparam int ID_W = PCKG_SZ - ID_MSB_OFS + 1;

    for (genvar i = 0; i < TERMS; i++) begin : g_term
        localparam logic [FIELD_W-1:0] MY_ROW = FIELD_W'(term_row(i, ROWS, COLUMS));
        localparam logic [FIELD_W-1:0] MY_COL = FIELD_W'(term_col(i, ROWS, COLUMS));

        logic               fifo_full;
        logic               fifo_empty;
        logic [PCKG_SZ-1:0] fifo_head;
        logic               tx_popped;
        logic               tx_dropped;

        rx_state_e          state_q;
        rx_state_e          state_d;
        logic               pop_o;
        logic               valid_o;
        logic [PCKG_SZ-1:0] rx_data_q;
        logic               ovf_q;
        logic               mis_q;
        logic [CNT_W-1:0]   tx_cnt_q;
        logic [CNT_W-1:0]   rx_cnt_q;
        logic               is_misrouted;

        mesh_term_fifo #(
            .PCKG_SZ    (PCKG_SZ),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (bus.push[i]),
            .push_data (bus.push_data[i*PCKG_SZ +: PCKG_SZ]),
            .pop       (bus.popin[i]),
            .full      (fifo_full),
            .empty     (fifo_empty),
            .head      (fifo_head),
            .popped    (tx_popped),
            .dropped   (tx_dropped)
        );

        // Broadcast ID is compared zero-extended to the full ID field.
        assign is_misrouted =
            ((rx_data_q[PCKG_SZ-ROW_MSB_OFS -: FIELD_W] != MY_ROW) ||
             (rx_data_q[PCKG_SZ-COL_MSB_OFS -: FIELD_W] != MY_COL)) &&
            (rx_data_q[ID_W-1:0] != ID_W'(BDCST));

        // RX state register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) state_q <= RX_IDLE;
            else        state_q <= state_d;
        end

        // RX next state and strobes; rx_ready only matters when starting.
        always_comb begin
            state_d = state_q;
            pop_o   = 1'b0;
            valid_o = 1'b0;
            case (state_q)
                RX_IDLE: if (bus.pndng[i] && bus.rx_ready[i]) state_d = RX_POP;
                RX_POP: begin
                    pop_o   = 1'b1;
                    state_d = RX_HOLD;
                end
                RX_HOLD: begin
                    valid_o = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end

        // Capture, sticky flags and saturating counters.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rx_data_q <= '0;
                ovf_q     <= 1'b0;
                mis_q     <= 1'b0;
                tx_cnt_q  <= '0;
                rx_cnt_q  <= '0;
            end else begin
                if (tx_dropped) ovf_q <= 1'b1;
                if (tx_popped && (tx_cnt_q != '1)) tx_cnt_q <= tx_cnt_q + 1'b1;
                if (state_q == RX_POP) rx_data_q <= bus.data_out[i*PCKG_SZ +: PCKG_SZ];
                if (state_q == RX_HOLD) begin
                    if (rx_cnt_q != '1) rx_cnt_q <= rx_cnt_q + 1'b1;
                    if (is_misrouted)   mis_q    <= 1'b1;
                end
            end
        end

        assign bus.full[i]                              = fifo_full;
        assign bus.pndng_i_in[i]                        = !fifo_empty;
        assign bus.data_out_i_in[i*PCKG_SZ +: PCKG_SZ]  = fifo_head;
        assign bus.pop[i]                               = pop_o;
        assign bus.rx_valid[i]                          = valid_o;
        assign bus.rx_data[i*PCKG_SZ +: PCKG_SZ]        = rx_data_q;
        assign bus.ovf[i]                               = ovf_q;
        assign bus.misroute[i]                          = mis_q;
        assign bus.tx_cnt[i*CNT_W +: CNT_W]             = tx_cnt_q;
        assign bus.rx_cnt[i*CNT_W +: CNT_W]             = rx_cnt_q;
        assign bus.rx_state[i*2 +: 2]                   = state_q;
    end
endmodule

// File: tb/tb_mesh_term_agent.sv
// Directed plus randomized bench for mesh_term_agent, checked against a
// queue-based transaction model of every terminal.
module tb_mesh_term_agent;
    localparam int PS    = 40;
    localparam int DEPTH = 4;
    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int NT    = 2*NR + 2*NC;
    localparam int VW    = NT*PS;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mesh_term_agent_if #(.PCKG_SZ(PS), .TERMS(NT)) bus ();

    mesh_term_agent #(
        .PCKG_SZ(PS), .FIFO_DEPTH(DEPTH), .ROWS(NR), .COLUMS(NC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [PS-1:0] txq   [NT][$];   // host packets waiting toward the mesh
    logic [PS-1:0] meshq [NT][$];   // mesh packets waiting for the terminal
    bit            ovf_m [NT];
    bit            mis_m [NT];
    int            txc_m [NT];
    int            rxc_m [NT];
    int            age_m [NT];      // -1 no transfer, else cycles since start
    logic [PS-1:0] cap_m [NT];
    bit            took  [NT];

    function automatic int exp_row(input int i);
        if (i < NC)            return 0;
        if (i < 2*NC)          return NR + 1;
        if (i < 2*NC + NR)     return i - 2*NC + 1;
        return i - 2*NC - NR + 1;
    endfunction

    function automatic int exp_col(input int i);
        if (i < NC)            return i + 1;
        if (i < 2*NC)          return i - NC + 1;
        if (i < 2*NC + NR)     return 0;
        return NC + 1;
    endfunction

    function automatic bit wrong_dest(input int i, input logic [PS-1:0] p);
        int r, c;
        r = int'(p[31:28]);
        c = int'(p[27:24]);
        return ((r != exp_row(i)) || (c != exp_col(i))) && (p[23:0] != 24'h3FFFFF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            txq[i].delete();
            meshq[i].delete();
            ovf_m[i] = 0; mis_m[i] = 0;
            txc_m[i] = 0; rxc_m[i] = 0;
            age_m[i] = -1; cap_m[i] = '0; took[i] = 0;
        end
    endtask

    // Applies one rising edge worth of transactions to the model.
    task automatic model_edge();
        for (int i = 0; i < NT; i++) begin
            bit do_pop, was_full;
            took[i]  = 0;
            was_full = (txq[i].size() == DEPTH);
            do_pop   = bus.popin[i] && (txq[i].size() > 0);
            if (do_pop) begin
                void'(txq[i].pop_front());
                if (txc_m[i] < 65535) txc_m[i]++;
            end
            if (bus.push[i]) begin
                if (!was_full || do_pop) txq[i].push_back(bus.push_data[i*PS +: PS]);
                else                     ovf_m[i] = 1;
            end
            if (age_m[i] == -1) begin
                if (bus.pndng[i] && bus.rx_ready[i]) age_m[i] = 0;
            end else if (age_m[i] == 0) begin
                cap_m[i] = bus.data_out[i*PS +: PS];
                took[i]  = 1;
                age_m[i] = 1;
            end else begin
                if (rxc_m[i] < 65535) rxc_m[i]++;
                if (wrong_dest(i, cap_m[i])) mis_m[i] = 1;
                age_m[i] = -1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_mesh();
        for (int i = 0; i < NT; i++) begin
            bus.pndng[i] = (meshq[i].size() > 0);
            bus.data_out[i*PS +: PS] = (meshq[i].size() > 0) ? meshq[i][0] : '0;
        end
    endtask

    task automatic clear_inputs();
        bus.push = '0; bus.push_data = '0; bus.popin = '0;
        bus.pndng = '0; bus.data_out = '0; bus.rx_ready = '0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [NT-1:0]    e_full, e_pnd, e_pop, e_val, e_ovf, e_mis;
        logic [VW-1:0]    e_head, e_rxd;
        logic [NT*16-1:0] e_txc, e_rxc;
        for (int i = 0; i < NT; i++) begin
            e_full[i] = (txq[i].size() == DEPTH);
            e_pnd[i]  = (txq[i].size() > 0);
            e_pop[i]  = (age_m[i] == 0);
            e_val[i]  = (age_m[i] == 1);
            e_ovf[i]  = ovf_m[i];
            e_mis[i]  = mis_m[i];
            e_head[i*PS +: PS] = (txq[i].size() > 0) ? txq[i][0] : '0;
            e_rxd[i*PS +: PS]  = cap_m[i];
            e_txc[i*16 +: 16]  = 16'(txc_m[i]);
            e_rxc[i*16 +: 16]  = 16'(rxc_m[i]);
        end
        check({where, ".full"},          VW'(bus.full),          VW'(e_full));
        check({where, ".pndng_i_in"},    VW'(bus.pndng_i_in),    VW'(e_pnd));
        check({where, ".data_out_i_in"}, bus.data_out_i_in,      e_head);
        check({where, ".pop"},           VW'(bus.pop),           VW'(e_pop));
        check({where, ".rx_valid"},      VW'(bus.rx_valid),      VW'(e_val));
        check({where, ".rx_data"},       bus.rx_data,            e_rxd);
        check({where, ".ovf"},           VW'(bus.ovf),           VW'(e_ovf));
        check({where, ".misroute"},      VW'(bus.misroute),      VW'(e_mis));
        check({where, ".tx_cnt"},        VW'(bus.tx_cnt),        VW'(e_txc));
        check({where, ".rx_cnt"},        VW'(bus.rx_cnt),        VW'(e_rxc));
    endtask

    // One clock: model the edge, take the edge, retire mesh pops, compare.
    task automatic cycle(input string where);
        drive_mesh();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NT; i++) if (took[i]) void'(meshq[i].pop_front());
        check_all(where);
    endtask

    task automatic do_reset(input string where);
        reset = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        check_all({where, ".async"});
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all({where, ".held"});
        end
        reset = 1'b1;
    endtask

    function automatic logic [PS-1:0] mk_pkt(input int r, input int c, input logic [23:0] id);
        logic [PS-1:0] p;
        p = {8'($urandom), 4'(r), 4'(c), id};
        return p;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [PS-1:0] pkt;
        reset = 1'b0;
        clear_inputs();
        model_reset();

        do_reset("rst0");
        cycle("post_release");

        // Fill terminal 0, then overflow it.
        for (int k = 0; k < DEPTH; k++) begin
            bus.push[0] = 1'b1;
            bus.push_data[0 +: PS] = {8'h00, 32'($urandom)};
            cycle("fill0");
        end
        check("full0_after4", VW'(bus.full[0]), VW'(1'b1));
        bus.push_data[0 +: PS] = 40'hAB_CDEF_0123;
        cycle("ovf0");
        bus.push[0] = 1'b0;
        check("ovf0_set", VW'(bus.ovf[0]), VW'(1'b1));

        // Drain terminal 0 in push order.
        bus.popin[0] = 1'b1;
        repeat (DEPTH) cycle("drain0");
        bus.popin[0] = 1'b0;
        check("txcnt0_eq4", VW'(bus.tx_cnt[15:0]), VW'(16'd4));
        check("pndng0_clear", VW'(bus.pndng_i_in[0]), VW'(1'b0));

        // Correctly addressed RX on terminal 1 (row 0, col 2).
        meshq[1].push_back(mk_pkt(0, 2, 24'h000123));
        bus.rx_ready[1] = 1'b1;
        cycle("rx1_a");
        check("pop1_pulse", VW'(bus.pop[1]), VW'(1'b1));
        cycle("rx1_b");
        check("rxvalid1", VW'(bus.rx_valid[1]), VW'(1'b1));
        cycle("rx1_c");
        bus.rx_ready[1] = 1'b0;
        check("rxcnt1_eq1", VW'(bus.rx_cnt[31:16]), VW'(16'd1));
        check("mis1_clear", VW'(bus.misroute[1]), VW'(1'b0));

        // rx_ready dropping during the pop cycle does not cancel delivery.
        meshq[3].push_back(mk_pkt(0, 4, 24'h000042));
        bus.rx_ready[3] = 1'b1;
        cycle("rx3_a");
        bus.rx_ready[3] = 1'b0;
        cycle("rx3_b");
        check("rxvalid3_noready", VW'(bus.rx_valid[3]), VW'(1'b1));
        cycle("rx3_c");

        // Misrouted packet on terminal 0.
        meshq[0].push_back(mk_pkt(3, 3, 24'h000055));
        bus.rx_ready[0] = 1'b1;
        repeat (3) cycle("mis0");
        check("mis0_set", VW'(bus.misroute[0]), VW'(1'b1));

        // Same coordinates with broadcast ID after a fresh reset.
        do_reset("rst1");
        meshq[0].push_back(mk_pkt(3, 3, 24'h3FFFFF));
        bus.rx_ready[0] = 1'b1;
        repeat (3) cycle("bcast0");
        bus.rx_ready[0] = 1'b0;
        check("bcast0_nomis", VW'(bus.misroute[0]), VW'(1'b0));
        check("bcast0_cnt", VW'(bus.rx_cnt[15:0]), VW'(16'd1));

        // Full FIFO on terminal 2 with push and popin on the same edge.
        for (int k = 0; k < DEPTH; k++) begin
            bus.push[2] = 1'b1;
            bus.push_data[2*PS +: PS] = {8'h22, 32'($urandom)};
            cycle("fill2");
        end
        bus.popin[2] = 1'b1;
        bus.push_data[2*PS +: PS] = 40'h5A_5A5A_A5A5;
        cycle("pushpop2");
        bus.push[2] = 1'b0;
        bus.popin[2] = 1'b0;
        check("full2_kept", VW'(bus.full[2]), VW'(1'b1));
        check("ovf2_clear", VW'(bus.ovf[2]), VW'(1'b0));
        bus.popin[2] = 1'b1;
        repeat (DEPTH) cycle("drain2");
        bus.popin[2] = 1'b0;

        // Reset while terminal 5 is in its pop cycle with two TX entries.
        for (int k = 0; k < 2; k++) begin
            bus.push[5] = 1'b1;
            bus.push_data[5*PS +: PS] = {8'h55, 32'($urandom)};
            cycle("fill5");
        end
        bus.push[5] = 1'b0;
        meshq[5].push_back(mk_pkt(5, 2, 24'h000777));
        bus.rx_ready[5] = 1'b1;
        cycle("rx5_start");
        check("pop5_before_rst", VW'(bus.pop[5]), VW'(1'b1));
        do_reset("rst2");
        check("pop5_in_rst", VW'(bus.pop[5]), VW'(1'b0));
        bus.rx_ready = '1;
        repeat (3) begin
            cycle("after_rst2");
            check("rxvalid_after_rst2", VW'(bus.rx_valid), VW'(0));
        end

        // Randomized traffic on all terminals.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NT; i++) begin
                bus.push[i]     = ($urandom_range(0, 2) == 0);
                bus.push_data[i*PS +: PS] = {8'($urandom), 32'($urandom)};
                bus.popin[i]    = ($urandom_range(0, 2) == 0);
                bus.rx_ready[i] = ($urandom_range(0, 3) != 0);
                if ((meshq[i].size() < 3) && ($urandom_range(0, 4) == 0)) begin
                    case ($urandom_range(0, 2))
                        0:       pkt = mk_pkt(exp_row(i), exp_col(i), 24'($urandom));
                        1:       pkt = mk_pkt($urandom_range(0, 15), $urandom_range(0, 15), 24'h3FFFFF);
                        default: pkt = mk_pkt($urandom_range(0, 15), $urandom_range(0, 15), 24'($urandom));
                    endcase
                    meshq[i].push_back(pkt);
                end
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mesh_term_agent.md
MESH_TERM_AGENT -- requirements
Module: mesh_term_agent

Interface
REQ-001 Parameters SHALL be: PCKG_SZ 40, packet width; FIFO_DEPTH 4, TX entries per terminal, power of two ≥2; ROWS 4, mesh rows; COLUMS 4, mesh columns; TERMS 2*ROWS+2*COLUMS, terminal count; BDCST {PCKG_SZ-18{1'b1}}, broadcast ID value.
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 push  in  TERMS  host write strobe, per terminal.
REQ-005 push_data  in  TERMS*PCKG_SZ  host packet, per terminal, PCKG_SZ slice i.
REQ-006 full  out  TERMS  TX FIFO full, per terminal.
REQ-007 pndng_i_in  out  TERMS  packet pending toward mesh.
REQ-008 data_out_i_in  out  TERMS*PCKG_SZ  TX FIFO head toward mesh.
REQ-009 popin  in  TERMS  mesh consumed head.
REQ-010 pndng  in  TERMS  mesh has packet for terminal.
REQ-011 data_out  in  TERMS*PCKG_SZ  mesh output packet.
REQ-012 pop  out  TERMS  agent consumes mesh packet.
REQ-013 rx_ready  in  TERMS  host may accept RX packet.
REQ-014 rx_valid  out  TERMS  one-cycle RX packet strobe.
REQ-015 rx_data  out  TERMS*PCKG_SZ  captured RX packet.
REQ-016 ovf  out  TERMS  sticky: push dropped while full.
REQ-017 misroute  out  TERMS  sticky: RX destination mismatch.
REQ-018 tx_cnt, rx_cnt  out  TERMS*16 each  saturating packet counters.

Function
REQ-019 Packet fields SHALL be: row = bits [PCKG_SZ-9:PCKG_SZ-12], col = [PCKG_SZ-13:PCKG_SZ-16], ID = [PCKG_SZ-17:0] padded view of low PCKG_SZ-18 bits compared to BDCST.
REQ-020 Terminal coordinates SHALL be: i<COLUMS → (0, i+1); COLUMS≤i<2C → (ROWS+1, i-C+1); 2C≤i<2C+ROWS → (i-2C+1, 0); else (i-2C-ROWS+1, COLUMS+1).
REQ-021 TX: push with !full SHALL write push_data slice at tail in the same edge; push with full SHALL drop and set ovf.
REQ-022 pndng_i_in[i] SHALL equal !empty[i]; data_out_i_in slice SHALL equal FIFO head combinationally.
REQ-023 popin with !empty SHALL advance head and increment tx_cnt; popin while empty SHALL be ignored.
REQ-024 Simultaneous push and popin while full SHALL accept both; count unchanged; ovf not set.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 RX per-terminal FSM states: IDLE, POP, HOLD. IDLE→POP when pndng & rx_ready; POP asserts pop for exactly one cycle, captures data_out into rx_data, goes HOLD; HOLD asserts rx_valid for one cycle, returns IDLE. Minimum RX spacing 3 cycles.
REQ-027 In HOLD, captured row/col ≠ terminal coordinates and ID ≠ BDCST SHALL set misroute; packet still delivered and counted.
REQ-028 rx_cnt increments in HOLD; both counters saturate at 16'hFFFF.
REQ-029 rx_ready deasserted in POP SHALL not cancel the transfer.
REQ-030 All channels SHALL operate independently, no cross-channel arbitration.

Reset
REQ-031 reset low SHALL asynchronously clear pointers, occupancy, counters, ovf, misroute, rx_valid, pop, rx_data, and force FSM IDLE; full=0, pndng_i_in=0.
REQ-032 Reset mid-transfer SHALL discard FIFO contents and any captured packet; no pop or rx_valid during reset or the first edge after release.

Structure
REQ-033 Package mesh_term_pkg SHALL hold field offset constants, FSM state enum, counter width, and term_row/term_col functions.
REQ-034 One sub-module mesh_term_fifo (single-channel TX FIFO, PCKG_SZ/FIFO_DEPTH params) SHALL be instantiated TERMS times via generate.

Verification
REQ-035 Push 4 packets to terminal 0, no popin → full[0]=1 after 4th edge; 5th push → ovf[0]=1, count stays 4.
REQ-036 Then popin[0] four cycles → data_out_i_in heads in push order, tx_cnt[0]=4, pndng_i_in[0]=0.
REQ-037 pndng[1]=1, data_out row=0 col=2, rx_ready=1 → pop[1] one cycle, rx_valid next cycle, rx_data matches, misroute[1]=0, rx_cnt[1]=1.
REQ-038 pndng[0]=1 with row=3 col=3, ID≠BDCST → misroute[0]=1; same with ID=BDCST → misroute stays 0.
REQ-039 Full FIFO, push and popin same edge → full stays 1, ovf=0, new packet at tail.
REQ-040 Assert reset low while FSM in POP with FIFO 2 deep → all outputs 0 immediately; after release no rx_valid, pndng_i_in=0.
